// File: rtl/vram_arbiter_if.sv
// vram_arbiter bus bundle: display/CPU request ports and the VRAM port.
// slave is the arbiter side, master the requesters plus the VRAM.
interface vram_arbiter_if #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 16
);
  logic                 DISP_REQ;
  logic [ADDR_BITS-1:0] DISP_ADDR;
  logic                 DISP_ACK;
  logic                 DISP_VALID;
  logic [DATA_BITS-1:0] DISP_DATA;

  logic                 CPU_REQ;
  logic                 CPU_WRITE;
  logic [ADDR_BITS-1:0] CPU_ADDR;
  logic [DATA_BITS-1:0] CPU_WDATA;
  logic                 CPU_ACK;
  logic                 CPU_VALID;
  logic [DATA_BITS-1:0] CPU_RDATA;

  logic                 RAM_ENABLE;
  logic                 RAM_WRITE;
  logic [ADDR_BITS-1:0] RAM_ADDR;
  logic [DATA_BITS-1:0] RAM_DATA_IN;
  logic [DATA_BITS-1:0] RAM_DATA_OUT;

  modport slave (
    input  DISP_REQ, DISP_ADDR,
    input  CPU_REQ, CPU_WRITE,
    input  CPU_ADDR, CPU_WDATA,
    input  RAM_DATA_OUT,
    output DISP_ACK, DISP_VALID,
    output DISP_DATA,
    output CPU_ACK, CPU_VALID,
    output CPU_RDATA,
    output RAM_ENABLE, RAM_WRITE,
    output RAM_ADDR, RAM_DATA_IN
  );

  modport master (
    output DISP_REQ, DISP_ADDR,
    output CPU_REQ, CPU_WRITE,
    output CPU_ADDR, CPU_WDATA,
    output RAM_DATA_OUT,
    input  DISP_ACK, DISP_VALID,
    input  DISP_DATA,
    input  CPU_ACK, CPU_VALID,
    input  CPU_RDATA,
    input  RAM_ENABLE, RAM_WRITE,
    input  RAM_ADDR, RAM_DATA_IN
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between display scan-out and the CPU,
// display first, with a bounded CPU wait and tagged read return.
module vram_arbiter #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  vram_arbiter_if.slave bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    G_IDLE,
    G_DISP,
    G_CPU
  } grant_e;

  grant_e grant;

  logic [WW-1:0] wait_q, wait_d;
  logic tag_vld_q, tag_vld_d;
  logic tag_cpu_q, tag_cpu_d;
  logic disp_vld_q, disp_vld_d;
  logic cpu_vld_q, cpu_vld_d;
  logic [DATA_BITS-1:0] disp_data_q;
  logic [DATA_BITS-1:0] disp_data_d;
  logic [DATA_BITS-1:0] cpu_data_q;
  logic [DATA_BITS-1:0] cpu_data_d;

  // A saturated wait counter overrides display priority.
  always_comb begin
    grant = G_IDLE;
    if (!RESET) begin
      if (bus.CPU_REQ && wait_q == WMAX)
        grant = G_CPU;
      else if (bus.DISP_REQ)
        grant = G_DISP;
      else if (bus.CPU_REQ)
        grant = G_CPU;
    end
  end

  always_comb begin
    bus.DISP_ACK    = 1'b0;
    bus.CPU_ACK     = 1'b0;
    bus.RAM_ENABLE  = 1'b0;
    bus.RAM_WRITE   = 1'b0;
    bus.RAM_ADDR    = '0;
    bus.RAM_DATA_IN = '0;
    tag_vld_d       = 1'b0;
    tag_cpu_d       = 1'b0;
    unique case (grant)
      G_DISP: begin
        bus.DISP_ACK   = 1'b1;
        bus.RAM_ENABLE = 1'b1;
        bus.RAM_ADDR   = bus.DISP_ADDR;
        tag_vld_d      = 1'b1;
      end
      G_CPU: begin
        bus.CPU_ACK     = 1'b1;
        bus.RAM_ENABLE  = 1'b1;
        bus.RAM_WRITE   = bus.CPU_WRITE;
        bus.RAM_ADDR    = bus.CPU_ADDR;
        bus.RAM_DATA_IN = bus.CPU_WDATA;
        tag_vld_d       = !bus.CPU_WRITE;
        tag_cpu_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!bus.CPU_REQ || grant == G_CPU)
      wait_d = '0;
    else if (wait_q != WMAX)
      wait_d = wait_q + 1'b1;
  end

  // Second stage routes the VRAM read word to the tagged owner.
  always_comb begin
    disp_vld_d  = tag_vld_q && !tag_cpu_q;
    cpu_vld_d   = tag_vld_q && tag_cpu_q;
    disp_data_d = disp_data_q;
    cpu_data_d  = cpu_data_q;
    if (disp_vld_d)
      disp_data_d = bus.RAM_DATA_OUT;
    if (cpu_vld_d)
      cpu_data_d = bus.RAM_DATA_OUT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_q      <= '0;
      tag_vld_q   <= 1'b0;
      tag_cpu_q   <= 1'b0;
      disp_vld_q  <= 1'b0;
      cpu_vld_q   <= 1'b0;
      disp_data_q <= '0;
      cpu_data_q  <= '0;
    end else begin
      wait_q      <= wait_d;
      tag_vld_q   <= tag_vld_d;
      tag_cpu_q   <= tag_cpu_d;
      disp_vld_q  <= disp_vld_d;
      cpu_vld_q   <= cpu_vld_d;
      disp_data_q <= disp_data_d;
      cpu_data_q  <= cpu_data_d;
    end
  end

  assign bus.DISP_VALID = disp_vld_q;
  assign bus.DISP_DATA  = disp_data_q;
  assign bus.CPU_VALID  = cpu_vld_q;
  assign bus.CPU_RDATA  = cpu_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, read-return scoreboard and
// per-scenario directed checks.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  vram_arbiter_if #(.ADDR_BITS(11), .DATA_BITS(16)) bus ();

  vram_arbiter #(
    .ADDR_BITS(11),
    .DATA_BITS(16),
    .MAX_WAIT(4)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [15:0] mem [2048];
  logic [15:0] ref_mem [2048];

  // Registered read port; write-through output left unchanged.
  always @(posedge clk) begin
    if (bus.RAM_ENABLE) begin
      if (bus.RAM_WRITE)
        mem[bus.RAM_ADDR] <= bus.RAM_DATA_IN;
      else
        bus.RAM_DATA_OUT <= mem[bus.RAM_ADDR];
    end
  end

  typedef struct {
    bit          cpu;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  bit          got_cpu;
  logic [15:0] got_data;

  always @(negedge clk) begin
    if (bus.DISP_VALID || bus.CPU_VALID) begin
      total++;
      if (bus.DISP_VALID && bus.CPU_VALID) begin
        $display("FAIL sb_two_valid got both want one");
      end else if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected cyc %0d got valid want none",
                 cyc);
      end else begin
        e = sbq.pop_front();
        got_cpu  = bus.CPU_VALID;
        got_data = got_cpu ? bus.CPU_RDATA : bus.DISP_DATA;
        if (got_cpu !== e.cpu || got_data !== e.data ||
            cyc != e.due)
          $display("FAIL sb_return got cpu=%0b data=%h cyc=%0d want cpu=%0b data=%h cyc=%0d",
                   got_cpu, got_data, cyc, e.cpu, e.data, e.due);
        else
          passed++;
      end
    end
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.DISP_ACK)
        sbq.push_back('{1'b0, ref_mem[bus.DISP_ADDR], cyc + 2});
      if (bus.CPU_ACK) begin
        if (bus.CPU_WRITE)
          ref_mem[bus.CPU_ADDR] = bus.CPU_WDATA;
        else
          sbq.push_back('{1'b1, ref_mem[bus.CPU_ADDR], cyc + 2});
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    bus.DISP_REQ  = 1'b0;
    bus.CPU_REQ   = 1'b0;
    bus.CPU_WRITE = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 11'h001;
    bus.CPU_REQ   = 1'b1;
    bus.CPU_WRITE = 1'b1;
    bus.CPU_ADDR  = 11'h002;
    bus.CPU_WDATA = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.DISP_ACK !== 1'b0 || bus.CPU_ACK !== 1'b0 ||
          bus.RAM_ENABLE !== 1'b0 || bus.RAM_WRITE !== 1'b0)
        $display("FAIL rst_ack got d=%b c=%b en=%b we=%b want 0",
                 bus.DISP_ACK, bus.CPU_ACK,
                 bus.RAM_ENABLE, bus.RAM_WRITE);
      else
        passed++;
    end
    total++;
    if (bus.DISP_VALID !== 1'b0 || bus.CPU_VALID !== 1'b0 ||
        bus.DISP_DATA !== 16'h0 || bus.CPU_RDATA !== 16'h0)
      $display("FAIL rst_outs got dv=%b cv=%b dd=%h cd=%h want 0",
               bus.DISP_VALID, bus.CPU_VALID,
               bus.DISP_DATA, bus.CPU_RDATA);
    else
      passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.DISP_REQ  = 1'b0;
    bus.CPU_REQ   = 1'b0;
    bus.CPU_WRITE = 1'b0;
    bus.CPU_WDATA = 16'h0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    bus.CPU_REQ   = 1'b1;
    bus.CPU_WRITE = 1'b1;
    bus.CPU_ADDR  = 11'h123;
    bus.CPU_WDATA = 16'hBEEF;
    @(negedge clk);
    total++;
    if (bus.CPU_ACK !== 1'b1 || bus.RAM_WRITE !== 1'b1 ||
        bus.RAM_ADDR !== 11'h123 || bus.RAM_DATA_IN !== 16'hBEEF)
      $display("FAIL wr_grant got ack=%b we=%b a=%h d=%h want 1 1 123 beef",
               bus.CPU_ACK, bus.RAM_WRITE,
               bus.RAM_ADDR, bus.RAM_DATA_IN);
    else
      passed++;
    @(posedge clk); #1;
    bus.CPU_WRITE = 1'b0;
    bus.CPU_WDATA = 16'h0;
    @(negedge clk);
    total++;
    if (bus.CPU_ACK !== 1'b1 || bus.RAM_WRITE !== 1'b0 ||
        bus.RAM_DATA_IN !== 16'h0)
      $display("FAIL rd_grant got ack=%b we=%b d=%h want 1 0 0",
               bus.CPU_ACK, bus.RAM_WRITE, bus.RAM_DATA_IN);
    else
      passed++;
    @(posedge clk); #1;
    bus.CPU_REQ = 1'b0;
    @(negedge clk);
    total++;
    if (bus.CPU_VALID !== 1'b0)
      $display("FAIL wr_no_valid got %b want 0", bus.CPU_VALID);
    else
      passed++;
    @(negedge clk);
    total++;
    if (bus.CPU_VALID !== 1'b1 || bus.CPU_RDATA !== 16'hBEEF)
      $display("FAIL raw_data got v=%b d=%h want 1 beef",
               bus.CPU_VALID, bus.CPU_RDATA);
    else
      passed++;
    idle();
  endtask

  task automatic test_priority();
    logic ed, ec;
    logic [10:0] ea;
    @(posedge clk); #1;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 11'h020;
    bus.CPU_REQ   = 1'b1;
    bus.CPU_WRITE = 1'b0;
    bus.CPU_ADDR  = 11'h030;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ec = (c == 4 || c == 6);
      ed = !ec;
      ea = ec ? 11'h030 : 11'h020;
      total++;
      if (bus.DISP_ACK !== ed || bus.CPU_ACK !== ec ||
          bus.RAM_ADDR !== ea)
        $display("FAIL prio_c%0d got d=%b c=%b a=%h want %b %b %h",
                 c, bus.DISP_ACK, bus.CPU_ACK, bus.RAM_ADDR,
                 ed, ec, ea);
      else
        passed++;
      @(posedge clk); #1;
      if (c == 5)
        bus.DISP_REQ = 1'b0;
    end
    bus.CPU_REQ = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.DISP_REQ  = (k < 8);
      bus.DISP_ADDR = 11'(k < 8 ? k : 0);
      @(negedge clk);
      if (k < 8) begin
        total++;
        if (bus.DISP_ACK !== 1'b1)
          $display("FAIL stream_ack%0d got %b want 1",
                   k, bus.DISP_ACK);
        else
          passed++;
      end
      total++;
      if (k < 2) begin
        if (bus.DISP_VALID !== 1'b0)
          $display("FAIL stream_early%0d got %b want 0",
                   k, bus.DISP_VALID);
        else
          passed++;
      end else begin
        if (bus.DISP_VALID !== 1'b1 ||
            bus.DISP_DATA !== 16'(16'h1000 + k - 2))
          $display("FAIL stream_data%0d got v=%b d=%h want 1 %h",
                   k, bus.DISP_VALID, bus.DISP_DATA,
                   16'(16'h1000 + k - 2));
        else
          passed++;
      end
    end
    idle();
  endtask

  task automatic test_interleave();
    @(posedge clk); #1;
    bus.CPU_REQ   = 1'b1;
    bus.CPU_WRITE = 1'b0;
    bus.CPU_ADDR  = 11'h010;
    @(negedge clk);
    total++;
    if (bus.CPU_ACK !== 1'b1)
      $display("FAIL il_cpu_ack got %b want 1", bus.CPU_ACK);
    else
      passed++;
    @(posedge clk); #1;
    bus.CPU_REQ   = 1'b0;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 11'h011;
    @(negedge clk);
    total++;
    if (bus.DISP_ACK !== 1'b1)
      $display("FAIL il_disp_ack got %b want 1", bus.DISP_ACK);
    else
      passed++;
    @(posedge clk); #1;
    bus.DISP_REQ = 1'b0;
    @(negedge clk);
    total++;
    if (bus.CPU_VALID !== 1'b1 || bus.CPU_RDATA !== 16'hAAAA ||
        bus.DISP_VALID !== 1'b0 || bus.DISP_DATA !== 16'h1007)
      $display("FAIL il_cpu got cv=%b cd=%h dv=%b dd=%h want 1 aaaa 0 1007",
               bus.CPU_VALID, bus.CPU_RDATA,
               bus.DISP_VALID, bus.DISP_DATA);
    else
      passed++;
    @(negedge clk);
    total++;
    if (bus.DISP_VALID !== 1'b1 || bus.DISP_DATA !== 16'h5555 ||
        bus.CPU_VALID !== 1'b0 || bus.CPU_RDATA !== 16'hAAAA)
      $display("FAIL il_disp got dv=%b dd=%h cv=%b cd=%h want 1 5555 0 aaaa",
               bus.DISP_VALID, bus.DISP_DATA,
               bus.CPU_VALID, bus.CPU_RDATA);
    else
      passed++;
    idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 11'h005;
    @(negedge clk);
    total++;
    if (bus.DISP_ACK !== 1'b1)
      $display("FAIL rm_ack got %b want 1", bus.DISP_ACK);
    else
      passed++;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
      bus.DISP_REQ = 1'b0;
      rst = (c < 3);
      @(negedge clk);
      total++;
      if (bus.DISP_VALID !== 1'b0 || bus.DISP_ACK !== 1'b0)
        $display("FAIL rm_flush%0d got v=%b ack=%b want 0 0",
                 c, bus.DISP_VALID, bus.DISP_ACK);
      else
        passed++;
    end
    @(posedge clk); #1;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 11'h006;
    @(negedge clk);
    total++;
    if (bus.DISP_ACK !== 1'b1)
      $display("FAIL rm_ack2 got %b want 1", bus.DISP_ACK);
    else
      passed++;
    @(posedge clk); #1;
    bus.DISP_REQ = 1'b0;
    @(negedge clk);
    total++;
    if (bus.DISP_VALID !== 1'b0)
      $display("FAIL rm_lat1 got %b want 0", bus.DISP_VALID);
    else
      passed++;
    @(negedge clk);
    total++;
    if (bus.DISP_VALID !== 1'b1 || bus.DISP_DATA !== 16'h1006)
      $display("FAIL rm_lat2 got v=%b d=%h want 1 1006",
               bus.DISP_VALID, bus.DISP_DATA);
    else
      passed++;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    for (int i = 0; i < 8; i++) begin
      mem[i]     = 16'(16'h1000 + i);
      ref_mem[i] = 16'(16'h1000 + i);
    end
    mem[11'h010]     = 16'hAAAA;
    ref_mem[11'h010] = 16'hAAAA;
    mem[11'h011]     = 16'h5555;
    ref_mem[11'h011] = 16'h5555;
    bus.DISP_REQ  = 1'b0;
    bus.DISP_ADDR = '0;
    bus.CPU_REQ   = 1'b0;
    bus.CPU_WRITE = 1'b0;
    bus.CPU_ADDR  = '0;
    bus.CPU_WDATA = '0;

    test_reset();
    test_write_read();
    test_priority();
    test_stream();
    test_interleave();
    test_reset_mid();

    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0)
      $display("FAIL sb_drain got %0d pending want 0", sbq.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-port arbiter that shares the single-port 2K×16 VRAM between the display scan-out reader and the CPU read/write port. Each cycle it grants at most one request, drives the VRAM enable/write/address/data-in lines, and tags the access through a two-stage return pipeline so read data is routed back to the correct requester. Display reads have priority. A wait counter guarantees the CPU a slot after at most `MAX_WAIT` consecutive lost cycles. Sits between the display/CPU front-ends and the VRAM instance.

## Interface
- `ADDR_BITS`, 11, VRAM address width.
- `DATA_BITS`, 16, VRAM word width.
- `MAX_WAIT`, 4, CPU starvation limit in cycles; must be ≥1.

- `CLK`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `DISP_REQ`  in  1  display read request.
- `DISP_ADDR`  in  ADDR_BITS  display read address.
- `DISP_ACK`  out  1  display request accepted this cycle (combinational).
- `DISP_VALID`  out  1  `DISP_DATA` valid (registered, 1-cycle pulse).
- `DISP_DATA`  out  DATA_BITS  display read data (registered).
- `CPU_REQ`  in  1  CPU request.
- `CPU_WRITE`  in  1  1 = write, 0 = read.
- `CPU_ADDR`  in  ADDR_BITS  CPU address.
- `CPU_WDATA`  in  DATA_BITS  CPU write data.
- `CPU_ACK`  out  1  CPU request accepted this cycle (combinational).
- `CPU_VALID`  out  1  `CPU_RDATA` valid (registered, reads only).
- `CPU_RDATA`  out  DATA_BITS  CPU read data (registered).
- `RAM_ENABLE`  out  1  to VRAM enable.
- `RAM_WRITE`  out  1  to VRAM write.
- `RAM_ADDR`  out  ADDR_BITS  to VRAM address.
- `RAM_DATA_IN`  out  DATA_BITS  to VRAM write data.
- `RAM_DATA_OUT`  in  DATA_BITS  from VRAM registered read port (1-cycle latency).

## Operation
- Requester rule: REQ, ADDR, WRITE and WDATA are held stable until the cycle in which ACK=1. A request is consumed at the rising edge ending the ACK cycle. Requesters must not form a combinational path from ACK to REQ.
- Grant (combinational, RESET=0):
  - CPU_REQ=1 and wait_cnt==MAX_WAIT: CPU wins.
  - Otherwise DISP_REQ=1: display wins.
  - Otherwise CPU_REQ=1: CPU wins.
  - Otherwise idle.
- Granted cycle drives the VRAM lines:
  - RAM_ENABLE=1.
  - RAM_ADDR = winner's address.
  - RAM_WRITE = CPU_WRITE if the CPU wins, else 0.
  - RAM_DATA_IN = CPU_WDATA if the CPU wins, else 0.
- Idle, or RESET=1: RAM_ENABLE=0, RAM_WRITE=0, RAM_ADDR=0, RAM_DATA_IN=0, both ACK=0.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments each cycle CPU_REQ=1 and CPU is not granted; saturates at MAX_WAIT.
  - Clears to 0 on CPU grant or when CPU_REQ=0.
- Return pipeline:
  - Stage 1 tag register {valid, owner}: loaded at the ACK edge, for reads only; writes load valid=0.
  - Stage 2: in the following cycle RAM_DATA_OUT is captured into DISP_DATA or CPU_RDATA per owner, and the matching VALID is set for one cycle.
  - The non-owner data register holds its value.
- Writes produce no VALID. VRAM write-through output is ignored.
- Back-to-back grants every cycle are supported, giving full throughput of one access per cycle.

## Timing
- Reset values: DISP_VALID=0, CPU_VALID=0, DISP_DATA=0, CPU_RDATA=0, wait_cnt=0, tag valid=0. ACK and RAM_* are forced to 0 while RESET=1.
- Read latency: ACK in cycle N; VRAM data appears in cycle N+1; VALID=1 with data in cycle N+2.
- Ordering: VALIDs are returned in grant order. At most one VALID is high per cycle.
- Read-after-write: a CPU write granted in cycle N followed by any read of the same address granted in N+1 returns the new data.
- Simultaneous requests with wait_cnt<MAX_WAIT: display wins; CPU_ACK=0; wait_cnt increments.
- Starvation bound: with DISP_REQ held high and CPU_REQ held high from cycle N, CPU_ACK=1 no later than cycle N+MAX_WAIT.
- RESET mid-operation: in-flight tags are discarded, and no VALID is emitted in the cycles after RESET deasserts for accesses issued before it. A RESET during an ACK cycle cancels that grant; the request must be re-presented.

## Test plan
- Reset: hold RESET 3 cycles with both REQs high → both ACK=0, RAM_ENABLE=0, both VALID=0, both data outputs 0.
- CPU write then read: write 0xBEEF to 0x123, ACK in cycle N; read 0x123, ACK in N+1 → CPU_VALID=1 in N+3 with CPU_RDATA=0xBEEF; no VALID in N+2.
- Display priority: both REQs high, MAX_WAIT=4 → DISP_ACK=1 on cycles 0–3; CPU_ACK=1 on cycle 4; DISP_ACK=1 again on cycle 5.
- Streaming display reads: preload addresses 0–7 with 0x1000+i; hold DISP_REQ with address incrementing on each ACK → DISP_VALID high 8 consecutive cycles, data 0x1000..0x1007 in order, starting 2 cycles after the first ACK.
- Interleaved owners: CPU read of 0x010 (contents 0xAAAA) then display read of 0x011 (contents 0x5555) on consecutive cycles → CPU_VALID/0xAAAA, then DISP_VALID/0x5555 the next cycle; the other data register is unchanged each time.
- Reset mid-read: RESET asserted in the cycle after a DISP_ACK → DISP_VALID never asserts for that access; first access after reset completes with normal 2-cycle latency.
